// File: rtl/ram256x32_arbiter.sv
// Round-robin arbiter and access sequencer for two clients sharing one ram256x32 macro.
// Optional port-B write protection above PROT_BASE is compiled in with RAM_ARB_WPROT_EN.
`timescale 1ns/1ps
module ram256x32_arbiter #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [7:0] PROT_BASE   = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        we_a,
    input  logic [7:0]  addr_a,
    input  logic [31:0] wdata_a,
    output logic        ack_a,
    output logic [31:0] rdata_a,
    input  logic        req_b,
    input  logic        we_b,
    input  logic [7:0]  addr_b,
    input  logic [31:0] wdata_b,
    output logic        ack_b,
    output logic [31:0] rdata_b,
    output logic        err_b,
    output logic        busy,
    output logic        ram_cs,
    output logic        ram_rw,
    output logic [7:0]  ram_adrs,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic       rr_ptr;   // 0 = A has priority on a tie, 1 = B
    logic       win;      // 0 = A, 1 = B
    logic       we_l;
    logic       prot_l;
    logic [3:0] cnt;
    logic       grant_b;
    logic       prot_hit;

    always_comb begin
        grant_b = req_b && (!req_a || rr_ptr);
`ifdef RAM_ARB_WPROT_EN
        prot_hit = grant_b && we_b && (addr_b >= PROT_BASE);
`else
        prot_hit = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            win         <= 1'b0;
            we_l        <= 1'b0;
            prot_l      <= 1'b0;
            cnt         <= 4'd0;
            ram_cs      <= 1'b1;
            ram_rw      <= 1'b0;
            ram_adrs    <= 8'd0;
            ram_data_in <= 32'd0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            err_b       <= 1'b0;
            rdata_a     <= 32'd0;
            rdata_b     <= 32'd0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ram_cs <= 1'b1;
                    ram_rw <= 1'b0;
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    err_b  <= 1'b0;
                    if (req_a || req_b) begin
                        win         <= grant_b;
                        we_l        <= grant_b ? we_b : we_a;
                        ram_adrs    <= grant_b ? addr_b : addr_a;
                        ram_data_in <= grant_b ? wdata_b : wdata_a;
                        prot_l      <= prot_hit;
                        ram_cs      <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    // Strobe write only after a full cycle of address setup.
                    ram_rw <= we_l && !prot_l;
                    cnt    <= CNT_INIT;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // rw drops with cs here; address/data stay put through DONE for hold.
                        ram_cs <= 1'b1;
                        ram_rw <= 1'b0;
                        if (!we_l) begin
                            if (win) rdata_b <= ram_data_out;
                            else     rdata_a <= ram_data_out;
                        end
                        ack_a <= !win;
                        ack_b <= win;
                        err_b <= prot_l;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    err_b  <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= !win;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram256x32_arbiter.sv
// Self-checking bench for ram256x32_arbiter: vector table, directed corner cases and
// randomized traffic against a word-level model of memory contents and client read data.
`timescale 1ns/1ps
module tb_ram256x32_arbiter;

    localparam int W  = 1;
    localparam int W3 = 3;
`ifdef RAM_ARB_WPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif
    localparam logic [31:0] PRE1   = 32'h1111_0001;
    localparam logic [31:0] PRE2   = 32'h2222_0002;
    localparam logic [31:0] PRE_F5 = 32'h0BAD_F005;
    localparam logic [31:0] PRE_FF = 32'h5A5A_00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, we_a, req_b, we_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ack_a, ack_b, err_b, busy;
    logic [31:0] rdata_a, rdata_b;
    logic        ram_cs, ram_rw;
    logic [7:0]  ram_adrs;
    logic [31:0] ram_data_in, ram_data_out;

    logic        req_b3;
    logic [7:0]  addr_b3;
    logic        ack_a3, ack_b3, err_b3, busy3, ram_cs3, ram_rw3;
    logic [31:0] rdata_a3, rdata_b3, ram_data_in3, ram_data_out3;
    logic [7:0]  ram_adrs3;

    always #5 clk = ~clk;

    ram256x32_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b), .err_b(err_b), .busy(busy),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_adrs(ram_adrs),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    ram256x32_arbiter #(.WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .rst(rst),
        .req_a(1'b0), .we_a(1'b0), .addr_a(8'h00), .wdata_a(32'h0),
        .ack_a(ack_a3), .rdata_a(rdata_a3),
        .req_b(req_b3), .we_b(1'b0), .addr_b(addr_b3), .wdata_b(32'h0),
        .ack_b(ack_b3), .rdata_b(rdata_b3), .err_b(err_b3), .busy(busy3),
        .ram_cs(ram_cs3), .ram_rw(ram_rw3), .ram_adrs(ram_adrs3),
        .ram_data_in(ram_data_in3), .ram_data_out(ram_data_out3)
    );

    // RAM models: main one is writable, the WAIT_CYCLES=3 one is read-only content.
    logic [31:0] ram_mem [256];
    assign ram_data_out  = ram_mem[ram_adrs];
    assign ram_data_out3 = (ram_adrs3 == 8'hFF) ? PRE_FF : 32'h0;
    always @(posedge clk) if (!ram_cs && ram_rw) ram_mem[ram_adrs] <= ram_data_in;

    // Reference model
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd  [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input bit p);
        return p ? ack_b : ack_a;
    endfunction

    // One transaction on the WAIT_CYCLES=1 instance, starting from IDLE.
    task automatic do_txn(input bit port, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
        bit prot;
        bit got;
        int k, cs_lo, rw_hi, busy_n;
        prot = PROT_EN && port && we && (addr >= 8'hF0);
        @(negedge clk);
        if (port) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
        end
        got = 0; k = 0; cs_lo = 0; rw_hi = 0; busy_n = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (ack_of(port)) got = 1;
            else begin
                if (!ram_cs) cs_lo++;
                if (!ram_cs && ram_rw) rw_hi++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        check32("ack_seen", 32'(got), 32'd1);
        check32("ack_latency", k, W + 2);
        check32("cs_low_cycles", cs_lo, W + 1);
        check32("rw_high_cycles", rw_hi, (we && !prot) ? W : 0);
        check32("done_cs", 32'(ram_cs), 32'd1);
        check32("done_rw", 32'(ram_rw), 32'd0);
        check32("held_adrs", 32'(ram_adrs), 32'(addr));
        check32("other_ack", 32'(ack_of(!port)), 32'd0);
        check32("err_b", 32'(err_b), 32'(prot));
        if (!we) exp_rd[port] = ref_mem[addr];
        else if (!prot) ref_mem[addr] = wdata;
        check32("rdata_a", rdata_a, exp_rd[0]);
        check32("rdata_b", rdata_b, exp_rd[1]);
        @(negedge clk);
        check32("ack_one_cycle", 32'(ack_of(port)), 32'd0);
        check32("busy_after", 32'(busy), 32'd0);
        check32("busy_cycles", busy_n, W + 2);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!rst && ack_a && ack_b) begin
            errors++;
            $display("FAIL dual_ack: got ack_a=1 ack_b=1 expected at most one");
        end
        if (!rst && err_b && !ack_b) begin
            errors++;
            $display("FAIL err_without_ack: got err_b=1 ack_b=0 expected err_b=0");
        end
    end

    initial begin
        int n, cyc, last;
        bit p, we;
        logic [7:0] a;
        logic [31:0] d;

        rst = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        req_b3 = 0; addr_b3 = 0;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ref_mem[i] = d;
            ram_mem[i] <= d;
        end
        ref_mem[8'h01] = PRE1;   ram_mem[8'h01] <= PRE1;
        ref_mem[8'h02] = PRE2;   ram_mem[8'h02] <= PRE2;
        ref_mem[8'h20] = 32'h0;  ram_mem[8'h20] <= 32'h0;
        ref_mem[8'hF5] = PRE_F5; ram_mem[8'hF5] <= PRE_F5;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 8'h30, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 8'h01, 32'h0,        PRE1};
        vecs[5] = '{1'b1, 1'b0, 8'h02, 32'h0,        PRE2};

        #12;
        check32("rst_cs", 32'(ram_cs), 32'd1);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_rdata_a", rdata_a, 32'h0);
        check32("rst_adrs", 32'(ram_adrs), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (!vecs[i].we)
                check32("vec_rdata", vecs[i].port ? rdata_b : rdata_a, vecs[i].exp);
        end

        // Protected region: B write blocked only when the feature is built in.
        do_txn(1'b1, 1'b1, 8'hF5, 32'h12345678);
        do_txn(1'b1, 1'b0, 8'hF5, 32'h0);
        check32("prot_readback", rdata_b, PROT_EN ? PRE_F5 : 32'h12345678);
        do_txn(1'b0, 1'b1, 8'hF5, 32'hCAFE0001);
        do_txn(1'b0, 1'b0, 8'hF5, 32'h0);
        check32("porta_f5_readback", rdata_a, 32'hCAFE0001);

        // WAIT_CYCLES=3 instance: port B read of 8'hFF.
        @(negedge clk);
        req_b3 = 1'b1; addr_b3 = 8'hFF;
        n = 0; cyc = 0; last = 0;
        while (!ack_b3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy3) last++;
            if (!ram_cs3) n++;
        end
        req_b3 = 1'b0;
        check32("w3_ack_latency", cyc, W3 + 2);
        check32("w3_cs_low", n, W3 + 1);
        check32("w3_rdata_b", rdata_b3, PRE_FF);
        @(negedge clk);
        check32("w3_busy_after", 32'(busy3), 32'd0);
        check32("w3_busy_cycles", last, W3 + 2);

        // Reset during ACCESS of a port A write to 8'h20.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h20; wdata_a = 32'hA5A55A5A;
        @(negedge clk);
        @(negedge clk);
        check32("access_cs", 32'(ram_cs), 32'd0);
        check32("access_rw", 32'(ram_rw), 32'd1);
        #2;
        rst = 1'b1;
        req_a = 1'b0;
        #1;
        check32("async_rst_cs", 32'(ram_cs), 32'd1);
        check32("async_rst_rw", 32'(ram_rw), 32'd0);
        check32("async_rst_adrs", 32'(ram_adrs), 32'd0);
        check32("async_rst_din", ram_data_in, 32'h0);
        check32("async_rst_ack", {ack_a, ack_b}, 32'd0);
        check32("async_rst_rdata_a", rdata_a, 32'h0);
        check32("async_rst_rdata_b", rdata_b, 32'h0);
        check32("async_rst_busy", 32'(busy), 32'd0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check32("abort_no_ack", 32'(ack_a), 32'd0);
        end

        // Fairness straight after reset: A first, then strict alternation.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 8'h01;
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'h02;
        n = 0; cyc = 0; last = 0;
        while (n < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (ack_a || ack_b) begin
                check32("rr_order", 32'(ack_b), 32'(n % 2));
                if (ack_b) check32("rr_rdata_b", rdata_b, ref_mem[8'h02]);
                else       check32("rr_rdata_a", rdata_a, ref_mem[8'h01]);
                if (n > 0) check32("rr_period", cyc - last, W + 3);
                last = cyc;
                n++;
                if (n == 4) begin
                    req_a = 1'b0; req_b = 1'b0;
                end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        check32("rr_count", n, 4);
        exp_rd[0] = ref_mem[8'h01];
        exp_rd[1] = ref_mem[8'h02];
        @(negedge clk);

        do_txn(1'b0, 1'b0, 8'h20, 32'h0);
        check32("abort_old_value", rdata_a, 32'h0);

        // Randomized traffic, biased to a few addresses including the protected range.
        for (int i = 0; i < 40; i++) begin
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'h40;
            a  = a + 8'($urandom_range(0, 7));
            d  = $urandom;
            do_txn(p, we, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
